minibus_arbiter_n: RTL

//  N-channel minibus master arbiter; successor to the single-master datapath memory controller.

---
 rtl/minibus_arbiter_n.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/minibus_arbiter_n.sv
// minibus_arbiter_n: N-channel minibus master arbiter.
// Arbitrates between NCH requesters and holds the winning request on the bus
// until the slave acks or the bounded wait expires. It then returns a one-cycle
// done/err pulse to the granted channel.
module minibus_arbiter_n #(
  parameter int NCH     = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_ren,
  input  logic [NCH-1:0]    ch_wen,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_wdata,
  input  logic [NCH*2-1:0]  ch_width,
  output logic [NCH-1:0]    ch_done,
  output logic [NCH-1:0]    ch_err,
  output logic [DW-1:0]     ch_rdata,
  output logic [AW-1:0]     bus_addr,
  output logic [DW-1:0]     bus_wdata,
  output logic [1:0]        bus_width,
  output logic              bus_ren,
  output logic              bus_wen,
  input  logic              bus_ack,
  input  logic [DW-1:0]     bus_rdata,
  input  logic              bus_err
);

  localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    width_q, width_d;
  logic          wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [NCH-1:0] req;
  logic [GW-1:0]  sel;
  logic           busy, resp;

  assign req  = ch_ren | ch_wen;
  assign busy = (state_q == S_BUSY);
  assign resp = (state_q == S_RESP);

  // Pick the winner: scan from index 0 (fixed) or from rr_q with wrap (round-robin).
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NCH; i++) begin
      idx = (RR_MODE != 0) ? ((int'(rr_q) + i) % NCH) : i;
      if (!found && req[GW'(idx)]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

  // Transaction FSM: latch in IDLE, hold in BUSY until ack or timeout, pulse in RESP.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    width_d = width_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_BUSY;
          gnt_d   = sel;
          addr_d  = ch_addr[sel*AW +: AW];
          wdata_d = ch_wdata[sel*DW +: DW];
          width_d = ch_width[sel*2 +: 2];
          wr_d    = ch_wen[sel];
          cnt_d   = '0;
          err_d   = 1'b0;
          if (RR_MODE != 0) rr_d = (sel == GW'(NCH - 1)) ? '0 : sel + 1'b1;
        end
      end
      S_BUSY: begin
        // Saturating so a disabled timeout never wraps back into a false match.
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (bus_ack) begin
          state_d = S_RESP;
          err_d   = bus_err;
          if (!wr_q) rdata_d = bus_rdata;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and transaction registers; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      width_q <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      width_q <= width_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // The bus is quiet outside BUSY; fields come only from the latched copy.
  assign bus_addr  = busy ? addr_q  : '0;
  assign bus_wdata = busy ? wdata_q : '0;
  assign bus_width = busy ? width_q : 2'b00;
  assign bus_ren   = busy & ~wr_q;
  assign bus_wen   = busy & wr_q;
  assign ch_rdata  = rdata_q;

  for (genvar i = 0; i < NCH; i++) begin : g_resp
    assign ch_done[i] = resp && (gnt_q == GW'(i));
    assign ch_err[i]  = ch_done[i] & err_q;
  end

endmodule
